// File: rtl/exec_mem_pkg.sv
// Shared constants for the execute/memory slice and the upstream control decoder.
// The ALU opcode encoding is defined once here so both sides agree on it.
package exec_mem_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/exec_mem_unit_alu_core.sv
// Combinational 32-bit ALU with zero flag.
// Opcodes not listed in the package produce a zero result.
module alu_core
    import exec_mem_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    logic              w_slt;
    logic [DATA_W-1:0] w_result;

    assign w_slt = ($signed(i_a) < $signed(i_b));

    always_comb begin
        w_result = '0;
        case (i_op)
            ALU_AND: w_result = i_a & i_b;
            ALU_OR:  w_result = i_a | i_b;
            ALU_ADD: w_result = i_a + i_b;
            ALU_SUB: w_result = i_a - i_b;
            ALU_SLT: w_result = {{(DATA_W-1){1'b0}}, w_slt};
            default: w_result = '0;
        endcase
    end

    assign o_result = w_result;
    assign o_zero   = (w_result == '0);

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory slice: ALU, branch-target adder and word-addressed data memory.
// The memory is indexed by the ALU result; byte-offset and upper address bits are ignored.
module exec_mem_unit
    import exec_mem_pkg::*;
#(
    parameter int MEM_WORDS = 64
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [2:0]        alu_control,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [DATA_W-1:0] branch_offset,
    output logic [DATA_W-1:0] branch_target,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);

    localparam int ADDR_BITS = $clog2(MEM_WORDS);

    logic [DATA_W-1:0]    r_mem [MEM_WORDS];
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_unused_addr;

    alu_core u_alu_core (
        .i_a      (alu_a),
        .i_b      (alu_b),
        .i_op     (alu_control),
        .o_result (alu_out),
        .o_zero   (zero)
    );

    assign branch_target = pc_plus4 + {branch_offset[DATA_W-3:0], 2'b00};

    assign w_idx = alu_out[ADDR_BITS+1:2];

    // Aliasing is intentional: these bits take no part in addressing.
    assign w_unused_addr = ^{alu_out[DATA_W-1:ADDR_BITS+2], alu_out[1:0],
                             branch_offset[DATA_W-1:DATA_W-2]};

    // Every word is cleared while reset is high, which also discards any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (mem_write) begin
            r_mem[w_idx] <= write_data;
        end
    end

    assign read_data = mem_read ? r_mem[w_idx] : '0;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: directed plan steps followed by randomized
// traffic compared against a behavioural ALU/branch/memory model.
module tb_exec_mem_unit;
    import exec_mem_pkg::*;

    localparam int MW = 64;

    logic        clk;
    logic        rst;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem [MW];

    exec_mem_unit #(.MEM_WORDS(MW)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_control   (alu_control),
        .alu_out       (alu_out),
        .zero          (zero),
        .pc_plus4      (pc_plus4),
        .branch_offset (branch_offset),
        .branch_target (branch_target),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .write_data    (write_data),
        .read_data     (read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int m_idx(input logic [31:0] addr);
        return int'((addr / 4) % MW);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < MW; i++) m_mem[i] = 32'd0;
    endtask

    task automatic drive_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_control = op;
        alu_a       = a;
        alu_b       = b;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_alu;
        logic [31:0] e_rd;
        e_alu = m_alu(alu_control, alu_a, alu_b);
        e_rd  = mem_read ? m_mem[m_idx(e_alu)] : 32'd0;
        chk({tag, "_alu"}, alu_out, e_alu);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (e_alu == 32'd0)});
        chk({tag, "_bt"}, branch_target, pc_plus4 + branch_offset * 4);
        chk({tag, "_rd"}, read_data, e_rd);
    endtask

    initial begin
        rst = 1'b1;
        drive_alu(ALU_ADD, 32'd0, 32'd8);
        pc_plus4      = 32'd0;
        branch_offset = 32'd0;
        mem_write     = 1'b0;
        mem_read      = 1'b1;
        write_data    = 32'd0;
        clear_model();

        // reset state
        #1;
        chk("reset_rd", read_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_rd", read_data, 32'd0);

        // 1. ALU ops
        drive_alu(ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F); #1;
        chk("and", alu_out, 32'h00F0_000F);
        chk("and_zero", {31'd0, zero}, 32'd0);
        drive_alu(ALU_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F); #1;
        chk("or", alu_out, 32'hFFF0_0FFF);
        drive_alu(ALU_ADD, 32'hFFFF_FFFF, 32'd1); #1;
        chk("add_wrap", alu_out, 32'd0);
        chk("add_wrap_zero", {31'd0, zero}, 32'd1);
        drive_alu(ALU_SUB, 32'd5, 32'd7); #1;
        chk("sub", alu_out, 32'hFFFF_FFFE);
        chk("sub_zero", {31'd0, zero}, 32'd0);

        // 2. SLT signedness and undefined opcode
        drive_alu(ALU_SLT, 32'hFFFF_FFFF, 32'd1); #1;
        chk("slt_neg", alu_out, 32'd1);
        drive_alu(ALU_SLT, 32'd1, 32'hFFFF_FFFF); #1;
        chk("slt_pos", alu_out, 32'd0);
        chk("slt_pos_zero", {31'd0, zero}, 32'd1);
        drive_alu(3'b100, 32'h1234_5678, 32'h9ABC_DEF0); #1;
        chk("undef", alu_out, 32'd0);
        chk("undef_zero", {31'd0, zero}, 32'd1);

        // 3. branch adder
        pc_plus4 = 32'h0000_0010; branch_offset = 32'h0000_0003; #1;
        chk("bt_fwd", branch_target, 32'h0000_001C);
        branch_offset = 32'hFFFF_FFFC; #1;
        chk("bt_back", branch_target, 32'h0000_0000);

        // 4. store / load with aliasing
        @(negedge clk);
        drive_alu(ALU_ADD, 32'd0, 32'd8);
        mem_read = 1'b0; mem_write = 1'b1; write_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_write = 1'b0;
        m_mem[2] = 32'hDEAD_BEEF;
        mem_read = 1'b1; #1;
        chk("load8", read_data, 32'hDEAD_BEEF);
        alu_b = 32'd9; #1;
        chk("load9", read_data, 32'hDEAD_BEEF);
        alu_b = 32'd8 + MW * 4; #1;
        chk("load_alias", read_data, 32'hDEAD_BEEF);
        mem_read = 1'b0; #1;
        chk("noread", read_data, 32'd0);

        // 5. read-during-write at address 4
        @(negedge clk);
        alu_b = 32'd4; mem_write = 1'b1; write_data = 32'h1111_1111;
        @(posedge clk); #1;
        m_mem[1] = 32'h1111_1111;
        write_data = 32'h2222_2222; mem_read = 1'b1; #1;
        chk("rdw_old", read_data, 32'h1111_1111);
        @(posedge clk); #1;
        m_mem[1] = 32'h2222_2222;
        mem_write = 1'b0;
        chk("rdw_new", read_data, 32'h2222_2222);

        // 6. asynchronous reset mid-cycle
        @(negedge clk); #2;
        alu_b = 32'd8; #1;
        chk("pre_rst_rd", read_data, 32'hDEAD_BEEF);
        mem_write = 1'b1; write_data = 32'hCAFE_F00D;
        rst = 1'b1; #1;
        clear_model();
        chk("async_rst_rd", read_data, 32'd0);
        @(posedge clk); #1;
        chk("rst_blocks_wr", read_data, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_write = 1'b0; #1;
        chk("after_rst_rd8", read_data, 32'd0);
        alu_b = 32'd4; #1;
        chk("after_rst_rd4", read_data, 32'd0);
        @(negedge clk);
        alu_b = 32'd8; mem_write = 1'b1; write_data = 32'h1234_5678;
        @(posedge clk); #1;
        mem_write = 1'b0;
        m_mem[2] = 32'h1234_5678; #1;
        chk("after_rst_wr", read_data, 32'h1234_5678);

        // randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 1)
                drive_alu(ALU_ADD, 32'($urandom_range(0, 1023)), 32'($urandom_range(0, 1023)));
            else
                drive_alu(3'($urandom_range(0, 7)), $urandom, $urandom);
            pc_plus4      = $urandom;
            branch_offset = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(16'($urandom)));
            mem_write     = 1'($urandom_range(0, 1));
            mem_read      = 1'($urandom_range(0, 3) != 0);
            write_data    = $urandom;
            #1;
            check_all("rand");
            @(posedge clk);
            if (mem_write) m_mem[m_idx(m_alu(alu_control, alu_a, alu_b))] = write_data;
        end

        @(negedge clk);
        mem_write = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_mem_unit.md
Name: exec_mem_unit

Overview:
Execute/memory slice of the single-cycle MIPS datapath. It contains three parts:
- a 32-bit ALU with a zero flag;
- the branch-target adder;
- a word-addressed data memory, addressed by the ALU result.

Register file, PC, instruction memory and the control muxes live outside this block.

Parameters:
DATA_W, 32, datapath width; fixed at 32 for MIPS.
MEM_WORDS, 64, data-memory depth in 32-bit words; must be a power of two.
ADDR_BITS, log2(MEM_WORDS), derived word-index width; not user-set.

Ports:
clk  input  1  system clock; memory writes occur on its rising edge.
rst  input  1  asynchronous, active-high reset.
alu_a  input  32  ALU operand A (register rs data).
alu_b  input  32  ALU operand B (rt data or sign-extended immediate, selected upstream).
alu_control  input  3  ALU operation select.
alu_out  output  32  ALU result; also the data-memory byte address.
zero  output  1  high when alu_out == 0.
pc_plus4  input  32  incremented PC.
branch_offset  input  32  sign-extended 16-bit immediate, not yet shifted.
branch_target  output  32  pc_plus4 + (branch_offset << 2).
mem_write  input  1  data-memory write enable.
mem_read  input  1  data-memory read enable.
write_data  input  32  store data (rt data).
read_data  output  32  load data.

Behaviour:
- ALU is purely combinational. Encoding of alu_control:
  - 000: AND
  - 001: OR
  - 010: ADD
  - 110: SUB (a - b)
  - 111: SLT, signed; result 32'd1 if $signed(a) < $signed(b), else 0
  - 011, 100, 101: result 0
- ADD and SUB wrap modulo 2^32. No overflow flag and no trap.
- zero is combinational: zero = (alu_out == 0). Undefined opcodes therefore give zero = 1.
- Branch adder is combinational: branch_target = pc_plus4 + {branch_offset[29:0], 2'b00}, wrapping modulo 2^32.
- Data memory holds MEM_WORDS x 32 bits.
- Addressing:
  - word index = alu_out[ADDR_BITS+1:2];
  - alu_out[1:0] is ignored (all accesses are word accesses);
  - bits above ADDR_BITS+1 are ignored, so addresses alias/wrap modulo MEM_WORDS*4.
- Read is combinational (0-cycle latency):
  - read_data = mem[index] when mem_read = 1;
  - read_data = 32'd0 when mem_read = 0.
- Write is synchronous: on the rising clk edge with mem_write = 1, mem[index] <= write_data.
- Read and write to the same index in the same cycle: read_data shows the old contents until the edge, then the new value.
- mem_read and mem_write both high is legal; the read-during-write rule above applies.
- Reset:
  - While rst is high, every memory word is 0 and writes are blocked.
  - Reset is asserted asynchronously (takes effect with no clock edge) and is released synchronously.
  - Reset during a pending write: the write is discarded.
- Outputs after reset:
  - alu_out, zero and branch_target depend only on their inputs (no state);
  - read_data = 0 for any address.
- No handshakes, no stalls, no internal state other than the memory array.

Decomposition:
- Shared package exec_mem_pkg holds:
  - DATA_W;
  - ALU opcode localparams ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_SLT = 3'b111.
  The control decoder imports the same constants.
- One natural sub-module, alu_core: the combinational ALU plus zero flag.
- The branch adder and the memory array stay inline in exec_mem_unit.

Test Plan:
1. ALU ops, each checked against zero:
   - a = 32'hF0F0_00FF, b = 32'h0FF0_0F0F: AND -> 32'h00F0_000F, OR -> 32'hFFF0_0FFF.
   - ADD 32'hFFFF_FFFF + 1 -> 0 with zero = 1.
   - SUB 5 - 7 -> 32'hFFFF_FFFE with zero = 0.
2. SLT signedness:
   - a = 32'hFFFF_FFFF (-1), b = 1 -> alu_out = 1.
   - a = 1, b = -1 -> alu_out = 0, zero = 1.
   - Undefined opcode 3'b100 -> alu_out = 0, zero = 1.
3. Branch adder:
   - pc_plus4 = 32'h0000_0010, offset = 32'h0000_0003 -> branch_target = 32'h0000_001C.
   - offset = 32'hFFFF_FFFC -> branch_target = 32'h0000_0000.
4. Memory store/load:
   - ADD 0 + 8, mem_write = 1, write_data = 32'hDEAD_BEEF for one edge.
   - Then mem_read = 1 at address 8 -> read_data = 32'hDEAD_BEEF.
   - Address 9 (low bits ignored) -> same data.
   - Address 8 + MEM_WORDS*4 (alias) -> same data.
   - mem_read = 0 -> read_data = 0.
5. Read-during-write at address 4 (old = 32'h1111_1111, new = 32'h2222_2222):
   - before the edge, read_data = 32'h1111_1111;
   - after the edge, read_data = 32'h2222_2222.
6. Asynchronous reset:
   - Assert rst mid-cycle with no clk edge -> read_data at address 8 goes to 0 immediately.
   - mem_write held high during reset -> no word is written.
   - After release, the first write/readback works normally.
